lcd_timing_gen: RTL and testbench

- Generates RGB-parallel LCD timing (DE, HSYNC, VSYNC) for the 480x272 panel.
- Runs on the PLL's divided pixel clock (clkoutd, ~9 MHz).
- Issues a pixel-request stream (x, y, valid) a fixed READ_LAT cycles ahead of DE, so a framebuffer/pattern source with fixed read latency can have pixel data aligned with lcd_de.
- It is the consumer side of the clock generator and the producer side of the panel interface.

---
 rtl/lcd_timing_pkg.sv | 33 +++
 rtl/lcd_delay_line.sv | 31 +++
 rtl/lcd_timing_gen.sv | 122 ++++++++++++
 tb/tb_lcd_timing_gen.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_timing_pkg.sv
// rtl/lcd_timing_pkg.sv - default 480x272 panel timing and counter/region helpers
// Provides the default timing set, derived totals and counter widths, and the
// region decode helpers shared by the timing generator.
package lcd_timing_pkg;

    localparam int DEF_H_ACTIVE = 480;
    localparam int DEF_H_FP     = 2;
    localparam int DEF_H_SYNC   = 41;
    localparam int DEF_H_BP     = 2;
    localparam int DEF_V_ACTIVE = 272;
    localparam int DEF_V_FP     = 2;
    localparam int DEF_V_SYNC   = 10;
    localparam int DEF_V_BP     = 2;
    localparam int DEF_READ_LAT = 2;

    function automatic int calc_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int cnt_width(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

    function automatic logic in_active(input int cnt, input int active);
        return cnt < active;
    endfunction

    // Sync region starts right after the front porch.
    function automatic logic in_sync(input int cnt, input int active, input int fp, input int sync);
        return (cnt >= active + fp) && (cnt < active + fp + sync);
    endfunction

endpackage

// File: rtl/lcd_delay_line.sv
// rtl/lcd_delay_line.sv - fixed-depth shift pipeline with per-bit reset value
// Ports: clk, reset (sync, active-high), din[WIDTH], dout[WIDTH] (din delayed DEPTH cycles).
module lcd_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= RESET_VAL;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/lcd_timing_gen.sv
// rtl/lcd_timing_gen.sv - RGB-parallel LCD timing generator with pixel-request lookahead
// Ports: clk (pixel clock), reset (sync, active-high), run (enable);
//        req_valid/req_x/req_y: pixel request READ_LAT cycles ahead of the panel;
//        lcd_de/lcd_hs/lcd_vs: panel timing; pix_x/pix_y: pixel under lcd_de;
//        frame_start/line_start: pulses coincident with first DE of frame / line.
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter int   READ_LAT = DEF_READ_LAT,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    localparam int  H_TOTAL  = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int  V_TOTAL  = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int  XW       = cnt_width(H_TOTAL),
    localparam int  YW       = cnt_width(V_TOTAL)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    output logic          req_valid,
    output logic [XW-1:0] req_x,
    output logic [YW-1:0] req_y,
    output logic          lcd_de,
    output logic          lcd_hs,
    output logic          lcd_vs,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic          frame_start,
    output logic          line_start
);

    localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] V_LAST = YW'(V_TOTAL - 1);

    // Pipeline word layout, LSB first: vs, hs, y, x, valid, line_start, frame_start.
    localparam int PW     = 5 + XW + YW;
    localparam int Y_LSB  = 2;
    localparam int X_LSB  = 2 + YW;
    localparam int V_BIT  = 2 + YW + XW;
    // Sync bits carry the panel level, so the idle word holds them inactive.
    localparam logic [PW-1:0] PIPE_RST = {3'b000, {XW{1'b0}}, {YW{1'b0}}, ~HS_POL, ~VS_POL};

    logic          run_q;
    logic [XW-1:0] h_cnt;
    logic [YW-1:0] v_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            run_q <= 1'b0;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            run_q <= run;
            if (!run_q) begin
                // Held at the origin so a restart always begins a fresh frame.
                h_cnt <= '0;
                v_cnt <= '0;
            end else if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    logic          h_act, v_act, h_syn, v_syn;
    logic          s0_valid_n, s0_hs_n, s0_vs_n, s0_ls_n, s0_fs_n;
    logic [XW-1:0] s0_x_n;
    logic [YW-1:0] s0_y_n;

    assign h_act = in_active(32'(h_cnt), H_ACTIVE);
    assign v_act = in_active(32'(v_cnt), V_ACTIVE);
    assign h_syn = in_sync(32'(h_cnt), H_ACTIVE, H_FP, H_SYNC);
    assign v_syn = in_sync(32'(v_cnt), V_ACTIVE, V_FP, V_SYNC);

    assign s0_valid_n = run_q & h_act & v_act;
    assign s0_x_n     = s0_valid_n ? h_cnt : '0;
    assign s0_y_n     = s0_valid_n ? v_cnt : '0;
    assign s0_hs_n    = (run_q & h_syn) ? HS_POL : ~HS_POL;
    assign s0_vs_n    = (run_q & v_syn) ? VS_POL : ~VS_POL;
    assign s0_ls_n    = s0_valid_n & (h_cnt == '0);
    assign s0_fs_n    = s0_ls_n & (v_cnt == '0);

    logic [PW-1:0] s0;

    always_ff @(posedge clk) begin
        if (reset) begin
            s0 <= PIPE_RST;
        end else begin
            s0 <= {s0_fs_n, s0_ls_n, s0_valid_n, s0_x_n, s0_y_n, s0_hs_n, s0_vs_n};
        end
    end

    assign req_valid = s0[V_BIT];
    assign req_x     = s0[X_LSB +: XW];
    assign req_y     = s0[Y_LSB +: YW];

    logic [PW-1:0] disp;

    lcd_delay_line #(
        .WIDTH     (PW),
        .DEPTH     (READ_LAT),
        .RESET_VAL (PIPE_RST)
    ) u_delay (
        .clk   (clk),
        .reset (reset),
        .din   (s0),
        .dout  (disp)
    );

    assign {frame_start, line_start, lcd_de, pix_x, pix_y, lcd_hs, lcd_vs} = disp;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb/tb_lcd_timing_gen.sv - self-checking bench for lcd_timing_gen
module tb_lcd_timing_gen;

    localparam int HA = 16, HFP = 2, HSW = 5, HBP = 3;
    localparam int VA = 6,  VFP = 2, VSW = 3, VBP = 2;
    localparam int RL = 4;
    localparam logic HSP = 1'b0;
    localparam logic VSP = 1'b1;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int F  = HT * VT;
    localparam int XW = $clog2(HT);
    localparam int YW = $clog2(VT);

    logic          clk = 1'b0;
    logic          reset;
    logic          run;
    logic          req_valid, lcd_de, lcd_hs, lcd_vs, frame_start, line_start;
    logic [XW-1:0] req_x, pix_x;
    logic [YW-1:0] req_y, pix_y;

    always #5 clk = ~clk;

    lcd_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
        .READ_LAT (RL), .HS_POL (HSP), .VS_POL (VSP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .req_valid   (req_valid),
        .req_x       (req_x),
        .req_y       (req_y),
        .lcd_de      (lcd_de),
        .lcd_hs      (lcd_hs),
        .lcd_vs      (lcd_vs),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .frame_start (frame_start),
        .line_start  (line_start)
    );

    typedef struct {
        bit valid;
        int x;
        int y;
        bit hs;
        bit vs;
    } tup_t;

    tup_t hist[$];
    bit   m_run_q;
    int   m_run_len;
    int   cyc;
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Request seen one cycle after the counter reaches a position that is
    // m_run_len cycles into an uninterrupted run.
    function automatic tup_t stage0_of(input bit rq, input int len);
        tup_t t;
        int pos, h, v;
        pos     = len % F;
        h       = pos % HT;
        v       = pos / HT;
        t.valid = rq && (h < HA) && (v < VA);
        t.x     = t.valid ? h : 0;
        t.y     = t.valid ? v : 0;
        t.hs    = rq && (h >= HA + HFP) && (h < HA + HFP + HSW);
        t.vs    = rq && (v >= VA + VFP) && (v < VA + VFP + VSW);
        return t;
    endfunction

    task automatic model_update(input logic r, input logic rn);
        tup_t t;
        if (r) begin
            t = '{default: 0};
            hist.delete();
            for (int i = 0; i <= RL; i++) hist.push_front(t);
            m_run_q   = 0;
            m_run_len = 0;
        end else begin
            t = stage0_of(m_run_q, m_run_len);
            hist.push_front(t);
            void'(hist.pop_back());
            m_run_len = m_run_q ? m_run_len + 1 : 0;
            m_run_q   = rn;
        end
    endtask

    task automatic check_all();
        tup_t s, d;
        s = hist[0];
        d = hist[RL];
        chk("req_valid",   req_valid,   s.valid);
        chk("req_x",       req_x,       s.x);
        chk("req_y",       req_y,       s.y);
        chk("lcd_de",      lcd_de,      d.valid);
        chk("pix_x",       pix_x,       d.x);
        chk("pix_y",       pix_y,       d.y);
        chk("lcd_hs",      lcd_hs,      d.hs ? HSP : !HSP);
        chk("lcd_vs",      lcd_vs,      d.vs ? VSP : !VSP);
        chk("frame_start", frame_start, d.valid && d.x == 0 && d.y == 0);
        chk("line_start",  line_start,  d.valid && d.x == 0);
    endtask

    task automatic step(input logic r, input logic rn);
        reset = r;
        run   = rn;
        @(posedge clk);
        cyc++;
        model_update(r, rn);
        @(negedge clk);
        check_all();
    endtask

    task automatic startup();
        step(1, 1);
        step(1, 1);
        chk("rst_hs", lcd_hs, !HSP);
        chk("rst_vs", lcd_vs, !VSP);
        chk("rst_de", lcd_de, 0);
        step(0, 1);
        chk("c1_req_valid", req_valid, 0);
        step(0, 1);
        chk("c2_req_valid", req_valid, 1);
        chk("c2_req_x", req_x, 0);
        chk("c2_req_y", req_y, 0);
        for (int i = 3; i <= RL + 1; i++) begin
            step(0, 1);
            chk("early_de", lcd_de, 0);
        end
        step(0, 1);
        chk("first_de", lcd_de, 1);
        chk("first_fs", frame_start, 1);
        chk("first_pix_x", pix_x, 0);
        chk("first_pix_y", pix_y, 0);
    endtask

    task automatic run_to(input int h, input int v);
        int guard = 0;
        while (!(m_run_q && (m_run_len % F) == v * HT + h) && guard < 2 * F) begin
            step(0, 1);
            guard++;
        end
        chk("run_to_bound", guard < 2 * F, 1);
    endtask

    task automatic steady(input int ncyc);
        int last_fs = -1, last_ls = -1, ls_cnt = 0;
        int de_run = 0, hs_run = 0, vs_run = 0;
        bit armed = 0;
        for (int i = 0; i < ncyc; i++) begin
            step(0, 1);
            if (frame_start === 1'b1) begin
                if (armed) begin
                    chk("fs_period", cyc - last_fs, F);
                    chk("ls_per_frame", ls_cnt, VA);
                end
                armed   = 1;
                last_fs = cyc;
                ls_cnt  = 0;
            end
            if (armed) begin
                if (line_start === 1'b1) begin
                    if (ls_cnt > 0) chk("line_period", cyc - last_ls, HT);
                    ls_cnt++;
                    last_ls = cyc;
                end
                if (lcd_de === 1'b1) de_run++;
                else begin
                    if (de_run > 0) chk("de_len", de_run, HA);
                    de_run = 0;
                end
                if (lcd_hs === HSP) begin
                    if (hs_run == 0 && cyc - last_ls < HT) chk("hs_offset", cyc - last_ls, HA + HFP);
                    hs_run++;
                end else begin
                    if (hs_run > 0) chk("hs_len", hs_run, HSW);
                    hs_run = 0;
                end
                if (lcd_vs === VSP) vs_run++;
                else begin
                    if (vs_run > 0) chk("vs_len", vs_run, VSW * HT);
                    vs_run = 0;
                end
            end
        end
    endtask

    initial begin
        bit r_run;
        cyc   = 0;
        reset = 1'b1;
        run   = 1'b0;
        @(negedge clk);

        startup();
        steady(3 * F + 20);

        run_to(10, 3);
        step(0, 0);
        chk("drop_req_k", req_valid, 1);
        step(0, 0);
        chk("drop_req_k1", req_valid, 0);
        for (int i = 2; i <= RL; i++) step(0, 0);
        chk("drop_de_still", lcd_de, 1);
        step(0, 0);
        chk("drop_de_low", lcd_de, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 0);
            chk("idle_de", lcd_de, 0);
        end
        step(0, 1);
        for (int i = 1; i <= RL; i++) begin
            step(0, 1);
            chk("rerun_no_fs", frame_start, 0);
        end
        step(0, 1);
        chk("rerun_fs", frame_start, 1);
        chk("rerun_pix_x", pix_x, 0);

        run_to(12, 2);
        step(1, 1);
        chk("midrst_de", lcd_de, 0);
        chk("midrst_pix_x", pix_x, 0);
        chk("midrst_pix_y", pix_y, 0);
        chk("midrst_hs", lcd_hs, !HSP);
        chk("midrst_vs", lcd_vs, !VSP);
        chk("midrst_req", req_valid, 0);
        startup();

        r_run = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(199) == 0) r_run = !r_run;
            step($urandom_range(699) == 0, r_run);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
